// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 256;

    // Requester indices: data cache and instruction cache.
    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 256
);
    // Port 0 (dcache)
    logic              req0_i;
    logic              write0_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [DATA_W-1:0] wdata0_i;
    logic              ack0_o;
    // Port 1 (icache)
    logic              req1_i;
    logic              write1_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata1_i;
    logic              ack1_o;
    // Shared read data back to requesters
    logic [DATA_W-1:0] rdata_o;
    // Memory side
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    // Arbiter view
    modport slave (
        input  req0_i, write0_i, addr0_i, wdata0_i,
        input  req1_i, write1_i, addr1_i, wdata1_i,
        output ack0_o, ack1_o, rdata_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    // Environment view (caches plus memory model)
    modport master (
        output req0_i, write0_i, addr0_i, wdata0_i,
        output req1_i, write1_i, addr1_i, wdata1_i,
        input  ack0_o, ack1_o, rdata_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin select: on contention the port that did
// not win last time is picked.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Winner selection from the request vector and the previous grant.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single off-chip line port. Serialises one
// memory transaction at a time with round-robin fairness under contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input logic           clk_i,
    input logic           rst_i,
    mem_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    logic              grant_valid;
    logic              grant_idx;

    rr_pick2 u_pick (
        .req         ({bus.req1_i, bus.req0_i}),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state and registered-output computation for the IDLE/BUSY/RESP FSM.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d  = BUSY;
                    owner_d  = grant_idx;
                    last_d   = grant_idx;
                    mem_en_d = 1'b1;
                    if (grant_idx == PORT_I) begin
                        mem_we_d   = bus.write1_i;
                        mem_addr_d = bus.addr1_i;
                        mem_data_d = bus.wdata1_i;
                    end else begin
                        mem_we_d   = bus.write0_i;
                        mem_addr_d = bus.addr0_i;
                        mem_data_d = bus.wdata0_i;
                    end
                end
            end
            BUSY: begin
                // Request inputs are deliberately not looked at here.
                if (bus.mem_ack_i) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    rdata_d  = bus.mem_data_i;
                    ack0_d   = (owner_q == PORT_D);
                    ack1_d   = (owner_q == PORT_I);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last_q resets to 1 so port 0
    // wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= PORT_D;
            last_q     <= PORT_I;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign bus.ack0_o       = ack0_q;
    assign bus.ack1_o       = ack1_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.mem_enable_o = mem_en_q;
    assign bus.mem_write_o  = mem_we_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

endmodule
